axil_slave_regbank: RTL and testbench
=====================================

# axil_slave_regbank

AXI4-Lite slave register bank sitting directly downstream of the AXI4-Lite master in `tt_um_axi4lite_top`. It accepts the master's write and read transactions, stores data in `NUM_REGS` registers with byte-strobe writes, and returns B/R responses. It replaces the ad-hoc slave memory so the top-level command interface (start_write/start_read, done) exercises a protocol-complete endpoint.

## Interface
- `ADDR_WIDTH`, 3, address bits; the address is a register index, with no byte offset.
- `DATA_WIDTH`, 8, data bits; must be a multiple of 8.
- `NUM_REGS`, 4, number of registers; 1 ≤ NUM_REGS ≤ 2^ADDR_WIDTH.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `awaddr`  in  ADDR_WIDTH  write address.
- `awvalid` in 1 / `awready` out 1  write-address handshake.
- `wdata`  in  DATA_WIDTH  write data.
- `wstrb`  in  DATA_WIDTH/8  byte enables.
- `wvalid` in 1 / `wready` out 1  write-data handshake.
- `bresp` out 2 / `bvalid` out 1 / `bready` in 1  write response.
- `araddr`  in  ADDR_WIDTH  read address.
- `arvalid` in 1 / `arready` out 1  read-address handshake.
- `rdata` out DATA_WIDTH / `rresp` out 2 / `rvalid` out 1 / `rready` in 1  read response.
- `regs_o`  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i is at bits [i*DW +: DW].

## Operation
- Write FSM has two states, WR_IDLE and WR_RESP. Two flags, `aw_held` and `w_held`, capture AW and W independently and in either order.
  - `awready = (state==WR_IDLE) & !aw_held`. `wready = (state==WR_IDLE) & !w_held`.
  - A capture happens at an edge with a handshake. The captured address or data plus strobe is held.
  - Once both AW and W are held or handshaking at the same edge, the register is written at that edge. Only the bytes with `wstrb[b]`=1 are written.
  - At that same edge, `bvalid` goes to 1 and the FSM moves to WR_RESP.
  - In WR_RESP, `bvalid`/`bresp` stay stable until `bready`. On the B handshake the flags clear and the FSM returns to WR_IDLE.
- Read FSM has two states, RD_IDLE and RD_DATA.
  - `arready = (state==RD_IDLE)`.
  - On the AR handshake, `rdata`/`rresp` are registered from the current register value, `rvalid` goes to 1, and the FSM moves to RD_DATA.
  - Outputs hold until `rready`, then the FSM returns to RD_IDLE.
- Read and write paths are fully independent and may be active in the same cycle.
- Out-of-range index (≥ NUM_REGS): behaviour is set by the macro in Configuration.

## Timing
- Reset values: all registers 0. `bvalid`, `rvalid` = 0. `bresp`, `rresp` = 2'b00. `rdata` = 0. Both FSMs are in IDLE.
- `awready`, `wready`, `arready` decode combinationally from state, so they are 1 during and immediately after reset.
- Write latency: the last of AW/W handshakes at edge k. The register and `regs_o` update at edge k, and `bvalid`=1 in cycle k+1.
- Read latency: AR handshake at edge k gives `rvalid`=1 with data in cycle k+1.
- Back-to-back: with `bready`/`rready` held at 1, a new transaction is accepted every 2 cycles per channel.
- Simultaneous read and write of the same register at the same edge: the read returns the pre-write value.
- `bready`/`rready` high before `valid` is legal; the handshake completes on the first edge where valid is also 1.
- Reset asserted mid-transaction clears all state immediately. Partially captured AW/W are discarded.

## Configuration
- `AXIL_REGBANK_SLVERR_EN` defined: out-of-range write is ignored with `bresp`=2'b10 (SLVERR); out-of-range read gives `rdata`=0 and `rresp`=2'b10.
- Not defined: out-of-range write is ignored with OKAY; out-of-range read returns 0 with OKAY.

## Structure
- Shared package `axil_pkg` holds `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10, plus the `wr_state_t` and `rd_state_t` enums.
- One sub-module, `axil_regfile`: the register array with a strobed write port, a combinational read port and the `regs_o` flattening.

## Test plan
Bench uses ADDR_WIDTH=3, DATA_WIDTH=8, NUM_REGS=4.
- AW(addr 2) and W(0x04, strb 1) in the same cycle, `bready`=1 -> `bvalid` next cycle with OKAY; `regs_o[23:16]`=0x04. Then AR(2) -> `rdata`=0x04, `rresp`=OKAY.
- W(0xA5) issued 3 cycles before AW(addr 1) -> `awready` stays 1 while `wready`=0 after capture; register 1 = 0xA5 after the AW handshake.
- Write 0x3C with `wstrb`=0 to register 0 -> B OKAY, register 0 stays 0x00.
- `bready` held at 0 for 5 cycles -> `bvalid`/`bresp` stable, `awready`=`wready`=0 throughout; the next write is accepted only after the B handshake.
- Same-edge write 0x77 and read of register 3 (previously 0x11) -> `rdata`=0x11; a following read returns 0x77.
- Write 0x55 and read at addr 6 -> with the macro: SLVERR and `rdata`=0x00. Without the macro: OKAY and 0x00. In both cases no register changes.
- `rst_n` pulsed low between the AW and W handshakes -> all registers 0 and both valids 0; the following W alone produces no write.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the slave register bank.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WrIdle,
    WrResp
  } wr_state_t;

  typedef enum logic {
    RdIdle,
    RdData
  } rd_state_t;

endpackage

// File: rtl/axil_regfile.sv
// Register array with a byte-strobed write port, a combinational read port and flattened contents.
module axil_regfile #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           we_i,
  input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb_i,
  input  logic [ADDR_WIDTH-1:0]          rd_addr_i,
  output logic [DATA_WIDTH-1:0]          rd_data_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        for (int unsigned b = 0; b < NumBytes; b++) begin
          if (32'(wr_addr_i) == i && wr_strb_i[b]) begin
            regs_d[i][b*8 +: 8] = wr_data_i[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Out-of-range indices match no register and read back as zero.
  always_comb begin
    rd_data_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_addr_i) == i) begin
        rd_data_o = regs_q[i];
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

endmodule

// File: rtl/axil_slave_regbank.sv
// AXI4-Lite slave register bank with independent write and read FSMs.
// Define AXIL_REGBANK_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_slave_regbank
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

`ifdef AXIL_REGBANK_SLVERR_EN
  localparam logic [1:0] OorResp = RESP_SLVERR;
`else
  localparam logic [1:0] OorResp = RESP_OKAY;
`endif

  wr_state_t               wr_state_q, wr_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d;

  rd_state_t               rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic                    aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0]   wr_addr_eff;
  logic [DATA_WIDTH-1:0]   wr_data_eff;
  logic [DATA_WIDTH/8-1:0] wr_strb_eff;
  logic                    wr_fire, wr_in_range, reg_we;
  logic                    rd_in_range;
  logic [DATA_WIDTH-1:0]   rd_data;

  axil_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .we_i      (reg_we),
    .wr_addr_i (wr_addr_eff),
    .wr_data_i (wr_data_eff),
    .wr_strb_i (wr_strb_eff),
    .rd_addr_i (araddr),
    .rd_data_o (rd_data),
    .regs_o    (regs_o)
  );

  // Output decode: ready/valid come straight from state so they are live during reset.
  always_comb begin
    awready = (wr_state_q == WrIdle) && !aw_held_q;
    wready  = (wr_state_q == WrIdle) && !w_held_q;
    bvalid  = (wr_state_q == WrResp);
    bresp   = bresp_q;
    arready = (rd_state_q == RdIdle);
    rvalid  = (rd_state_q == RdData);
    rdata   = rdata_q;
    rresp   = rresp_q;
  end

  // A channel handshaking this edge bypasses its holding register.
  always_comb begin
    aw_hs       = awvalid && awready;
    w_hs        = wvalid && wready;
    wr_addr_eff = aw_hs ? awaddr : awaddr_q;
    wr_data_eff = w_hs ? wdata : wdata_q;
    wr_strb_eff = w_hs ? wstrb : wstrb_q;
    wr_in_range = 32'(wr_addr_eff) < NUM_REGS;
    wr_fire     = (wr_state_q == WrIdle) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    reg_we      = wr_fire && wr_in_range;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    unique case (wr_state_q)
      WrIdle: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if (wr_fire) begin
          wr_state_d = WrResp;
          bresp_d    = wr_in_range ? RESP_OKAY : OorResp;
        end
      end
      WrResp: begin
        if (bready) begin
          wr_state_d = WrIdle;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    ar_hs       = arvalid && arready;
    rd_in_range = 32'(araddr) < NUM_REGS;
    rd_state_d  = rd_state_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    unique case (rd_state_q)
      RdIdle: begin
        if (ar_hs) begin
          rd_state_d = RdData;
          rdata_d    = rd_in_range ? rd_data : '0;
          rresp_d    = rd_in_range ? RESP_OKAY : OorResp;
        end
      end
      RdData: begin
        if (rready) begin
          rd_state_d = RdIdle;
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WrIdle;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rd_state_q <= RdIdle;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_slave_regbank.sv
// Scoreboard bench for axil_slave_regbank: stimulus pushes expected B/R responses, a monitor pops them.
module tb_axil_slave_regbank;

`ifdef AXIL_REGBANK_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif
  localparam logic [1:0] OKAY = 2'b00;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] resp;
  } r_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [7:0]  wdata = '0;
  logic [0:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [2:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [7:0]  rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] regs_o;

  int checks = 0;
  int errors = 0;
  logic [1:0] b_q[$];
  r_exp_t     r_q[$];

  axil_slave_regbank #(
    .ADDR_WIDTH (3),
    .DATA_WIDTH (8),
    .NUM_REGS   (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .regs_o  (regs_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (b_q.size() == 0) begin
        check("b_unexpected", 32'(bvalid), 32'd0);
      end else begin
        check("b_resp", 32'(bresp), 32'(b_q.pop_front()));
      end
    end
    if (rst_n && rvalid && rready) begin
      if (r_q.size() == 0) begin
        check("r_unexpected", 32'(rvalid), 32'd0);
      end else begin
        r_exp_t e;
        e = r_q.pop_front();
        check("r_data", 32'(rdata), 32'(e.data));
        check("r_resp", 32'(rresp), 32'(e.resp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [2:0] a, input logic [7:0] d, input logic s,
                           input logic [1:0] resp);
    logic aw_f, w_f;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    b_q.push_back(resp);
    for (int c = 0; c < 16 && (awvalid || wvalid); c++) begin
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      tick();
      if (aw_f) awvalid = 1'b0;
      if (w_f) wvalid = 1'b0;
    end
    check("wr_accept_timeout", 32'(awvalid || wvalid), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    check("b_latency", 32'(bvalid), 32'd1);
    tick();
  endtask

  task automatic axi_read(input logic [2:0] a, input logic [7:0] d, input logic [1:0] resp);
    logic f;
    araddr = a; arvalid = 1'b1;
    r_q.push_back('{data: d, resp: resp});
    for (int c = 0; c < 16 && arvalid; c++) begin
      f = arvalid && arready;
      tick();
      if (f) arvalid = 1'b0;
    end
    check("rd_accept_timeout", 32'(arvalid), 32'd0);
    arvalid = 1'b0;
    check("r_latency", 32'(rvalid), 32'd1);
    tick();
  endtask

  initial begin
    // Reset state, readies live during reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_regs", regs_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Simultaneous AW+W, then read back.
    axi_write(3'd2, 8'h04, 1'b1, OKAY);
    check("reg2_after_wr", 32'(regs_o[23:16]), 32'h04);
    axi_read(3'd2, 8'h04, OKAY);

    // W three cycles ahead of AW.
    wdata = 8'hA5; wstrb = 1'b1; wvalid = 1'b1;
    b_q.push_back(OKAY);
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wfirst_wready", 32'(wready), 32'd0);
      check("wfirst_awready", 32'(awready), 32'd1);
      check("wfirst_no_b", 32'(bvalid), 32'd0);
      tick();
    end
    awaddr = 3'd1; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("wfirst_bvalid", 32'(bvalid), 32'd1);
    check("reg1_after_wr", 32'(regs_o[15:8]), 32'hA5);
    tick();

    // Zero strobe writes nothing.
    axi_write(3'd0, 8'h3C, 1'b0, OKAY);
    check("reg0_strb0", 32'(regs_o[7:0]), 32'h00);

    // B backpressure; a pending write waits for the B handshake.
    bready = 1'b0;
    awaddr = 3'd3; wdata = 8'h11; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    b_q.push_back(OKAY);
    tick();
    check("stall_bvalid0", 32'(bvalid), 32'd1);
    awaddr = 3'd0; wdata = 8'h99; awvalid = 1'b1; wvalid = 1'b1;
    b_q.push_back(OKAY);
    for (int i = 0; i < 5; i++) begin
      check("stall_bvalid", 32'(bvalid), 32'd1);
      check("stall_bresp", 32'(bresp), 32'(OKAY));
      check("stall_awready", 32'(awready), 32'd0);
      check("stall_wready", 32'(wready), 32'd0);
      tick();
    end
    check("stall_reg0_held", 32'(regs_o[7:0]), 32'h00);
    bready = 1'b1;
    tick();
    check("after_b_bvalid", 32'(bvalid), 32'd0);
    check("after_b_awready", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("second_wr_bvalid", 32'(bvalid), 32'd1);
    check("reg0_after_stall", 32'(regs_o[7:0]), 32'h99);
    check("reg3_after_stall", 32'(regs_o[31:24]), 32'h11);
    tick();

    // Same-edge write and read of register 3 returns the old value.
    awaddr = 3'd3; wdata = 8'h77; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 3'd3; arvalid = 1'b1;
    b_q.push_back(OKAY);
    r_q.push_back('{data: 8'h11, resp: OKAY});
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same_edge_bvalid", 32'(bvalid), 32'd1);
    check("same_edge_rvalid", 32'(rvalid), 32'd1);
    tick();
    axi_read(3'd3, 8'h77, OKAY);

    // Out-of-range access.
    axi_write(3'd6, 8'h55, 1'b1, OOR);
    axi_read(3'd6, 8'h00, OOR);
    check("regs_after_oor", regs_o, 32'h7704A599);

    // Reset between AW and W discards the captured address.
    awaddr = 3'd1; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("pre_rst_awready", 32'(awready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_regs", regs_o, 32'd0);
    check("midrst_bvalid", 32'(bvalid), 32'd0);
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_awready", 32'(awready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wdata = 8'h5A; wstrb = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("w_alone_no_b", 32'(bvalid), 32'd0);
    check("w_alone_wready", 32'(wready), 32'd0);
    check("w_alone_regs", regs_o, 32'd0);
    tick();
    check("w_alone_no_b2", 32'(bvalid), 32'd0);
    tick();

    check("b_queue_empty", 32'(b_q.size()), 32'd0);
    check("r_queue_empty", 32'(r_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
